// File: rtl/frac_div_ctrl_pkg.sv
// Shared types and constants for the fractional clock divider controller.
// Optional legality checking of offered ratios is enabled by FRAC_DIV_CTRL_CHECK_EN.
package frac_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_e;

   localparam int DEF_INT = 2;
   localparam int DEF_NUM = 0;
   localparam int DEF_DEN = 1;
   localparam int MIN_INT = 2;

   // A ratio is usable when every period is at least MIN_INT cycles and num/den < 1.
   function automatic logic ratio_legal(input logic [31:0] i_val,
                                        input logic [31:0] n_val,
                                        input logic [31:0] d_val);
      return (i_val >= 32'(MIN_INT)) && (d_val != 32'd0) && (n_val < d_val);
   endfunction

endpackage

// File: rtl/frac_div_ctrl_if.sv
// Bundle of run control, ratio handshake and divided-clock outputs.
// Optional legality checking of offered ratios is enabled by FRAC_DIV_CTRL_CHECK_EN.
interface frac_div_ctrl_if #(
   parameter int CNT_W  = 8,
   parameter int FRAC_W = 8
);
   import frac_div_pkg::*;

   logic              en;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CNT_W-1:0]  cfg_int;
   logic [FRAC_W-1:0] cfg_num;
   logic [FRAC_W-1:0] cfg_den;
   logic              cfg_err;
   logic              clk_out;
   logic              tick;
   logic              busy;

   modport master (
      output en, cfg_valid, cfg_int, cfg_num, cfg_den,
      input  cfg_ready, cfg_err, clk_out, tick, busy
   );

   modport slave (
      input  en, cfg_valid, cfg_int, cfg_num, cfg_den,
      output cfg_ready, cfg_err, clk_out, tick, busy
   );

endinterface

// File: rtl/frac_div_ctrl_acc.sv
// Phase accumulator: decides whether the period starting now is long (int+1) or short (int).
// Optional legality checking of offered ratios is enabled by FRAC_DIV_CTRL_CHECK_EN.
module frac_div_acc #(
   parameter int FRAC_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              step_i,
   input  logic [FRAC_W-1:0] num_i,
   input  logic [FRAC_W-1:0] den_i,
   output logic              long_o
);
   import frac_div_pkg::*;

   logic [FRAC_W-1:0] acc_q, acc_d;
   logic [FRAC_W:0]   sum;
   logic [FRAC_W:0]   diff;

   // The extra sum bit keeps acc+num exact even when both are near full scale.
   assign sum    = {1'b0, acc_q} + {1'b0, num_i};
   assign diff   = sum - {1'b0, den_i};
   assign long_o = (sum >= {1'b0, den_i});

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (step_i) begin
         acc_d = long_o ? diff[FRAC_W-1:0] : sum[FRAC_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/frac_div_ctrl.sv
// Fractional clock divider controller: mixes int and int+1 periods, retimes ratio updates to boundaries.
// Optional legality checking of offered ratios is enabled by FRAC_DIV_CTRL_CHECK_EN.
module frac_div_ctrl
   import frac_div_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int FRAC_W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   frac_div_ctrl_if.slave ctrl
);

   localparam int LW = CNT_W + 1;

   state_e            state_q, state_d;
   logic [LW-1:0]     cnt_q, cnt_d;
   logic [LW-1:0]     len_q, len_d;
   logic              clk_out_q, clk_out_d;
   logic              tick_q, tick_d;
   logic              busy_q, busy_d;
   logic              ready_q, ready_d;
   logic              pend_q, pend_d;
   logic [CNT_W-1:0]  int_q, int_d, sh_int_q, sh_int_d;
   logic [FRAC_W-1:0] num_q, num_d, sh_num_q, sh_num_d;
   logic [FRAC_W-1:0] den_q, den_d, sh_den_q, sh_den_d;

   logic              acc_clr;
   logic              acc_long;
   logic              running;
   logic              first;
   logic              boundary;
   logic              xfer;
   logic              ok;
   logic [LW-1:0]     cur_len;
   logic [LW-1:0]     cnt_inc;

   assign running = (state_q != IDLE);
   assign first   = running && (cnt_q == '0);
   // The length is only known combinationally in the first cycle; later cycles use the latched copy.
   assign cur_len  = first ? ({1'b0, int_q} + LW'(acc_long)) : len_q;
   assign boundary = running && (cnt_q == (cur_len - LW'(1)));
   assign cnt_inc  = cnt_q + LW'(1);
   assign xfer     = ctrl.cfg_valid && ready_q;

`ifdef FRAC_DIV_CTRL_CHECK_EN
   logic err_q, err_d;

   assign ok    = ratio_legal(32'(ctrl.cfg_int), 32'(ctrl.cfg_num), 32'(ctrl.cfg_den));
   assign err_d = xfer && !ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign ctrl.cfg_err = err_q;
`else
   assign ok           = 1'b1;
   assign ctrl.cfg_err = 1'b0;
`endif

   frac_div_acc #(
      .FRAC_W (FRAC_W)
   ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (acc_clr),
      .step_i (first),
      .num_i  (num_q),
      .den_i  (den_q),
      .long_o (acc_long)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
      ready_d   = ready_q;
      pend_d    = pend_q;
      int_d     = int_q;
      num_d     = num_q;
      den_d     = den_q;
      sh_int_d  = sh_int_q;
      sh_num_d  = sh_num_q;
      sh_den_d  = sh_den_q;
      acc_clr   = 1'b0;

      case (state_q)
         IDLE: begin
            if (ctrl.en) begin
               state_d   = RUN;
               cnt_d     = '0;
               clk_out_d = 1'b1;
               tick_d    = 1'b1;
               acc_clr   = 1'b1;
            end
         end
         RUN, STOP: begin
            if (first) begin
               len_d = cur_len;
            end
            if (boundary) begin
               cnt_d = '0;
               // en high at the boundary edge starts the next period back-to-back.
               if (ctrl.en) begin
                  state_d   = RUN;
                  clk_out_d = 1'b1;
                  tick_d    = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d     = cnt_inc;
               clk_out_d = (cnt_inc < (cur_len >> 1));
               state_d   = ctrl.en ? RUN : STOP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (xfer && ok) begin
         if (state_q == IDLE) begin
            int_d = ctrl.cfg_int;
            num_d = ctrl.cfg_num;
            den_d = ctrl.cfg_den;
         end else begin
            sh_int_d = ctrl.cfg_int;
            sh_num_d = ctrl.cfg_num;
            sh_den_d = ctrl.cfg_den;
            pend_d   = 1'b1;
            ready_d  = 1'b0;
         end
      end

      // pend_q implies ready_q is low, so this never collides with a shadow write.
      if (boundary && pend_q) begin
         int_d   = sh_int_q;
         num_d   = sh_num_q;
         den_d   = sh_den_q;
         pend_d  = 1'b0;
         ready_d = 1'b1;
         acc_clr = 1'b1;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         len_q     <= LW'(DEF_INT);
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
         pend_q    <= 1'b0;
         int_q     <= CNT_W'(DEF_INT);
         num_q     <= FRAC_W'(DEF_NUM);
         den_q     <= FRAC_W'(DEF_DEN);
         sh_int_q  <= CNT_W'(DEF_INT);
         sh_num_q  <= FRAC_W'(DEF_NUM);
         sh_den_q  <= FRAC_W'(DEF_DEN);
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         pend_q    <= pend_d;
         int_q     <= int_d;
         num_q     <= num_d;
         den_q     <= den_d;
         sh_int_q  <= sh_int_d;
         sh_num_q  <= sh_num_d;
         sh_den_q  <= sh_den_d;
      end
   end

   assign ctrl.clk_out   = clk_out_q;
   assign ctrl.tick      = tick_q;
   assign ctrl.busy      = busy_q;
   assign ctrl.cfg_ready = ready_q;

endmodule

// File: tb/tb_frac_div_ctrl.sv
// Self-checking bench: observed periods (length, high cycles) are compared against an expected queue.
// Illegal-ratio checks apply only when FRAC_DIV_CTRL_CHECK_EN is defined.
module tb_frac_div_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   frac_div_ctrl_if #(.CNT_W(8), .FRAC_W(8)) bus ();

   frac_div_ctrl #(.CNT_W(8), .FRAC_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ctrl  (bus.slave)
   );

   typedef struct {
      int len;
      int hi;
   } per_t;

   typedef struct {
      int ci;
      int cn;
      int cd;
      int lens[6];
   } vec_t;

   per_t obs_q[$];
   per_t exp_q[$];
   vec_t vecs[6];
   int   n_chk   = 0;
   int   n_fail  = 0;
   int   err_cnt = 0;
   bit   in_p    = 1'b0;
   int   m_len   = 0;
   int   m_hi    = 0;

   // Period monitor: a period ends at the next tick or when busy falls.
   always @(negedge clk) begin
      if (bus.tick) begin
         if (in_p) obs_q.push_back('{m_len, m_hi});
         in_p  = 1'b1;
         m_len = 1;
         m_hi  = int'(bus.clk_out);
      end else if (in_p && !bus.busy) begin
         obs_q.push_back('{m_len, m_hi});
         in_p = 1'b0;
      end else if (in_p) begin
         m_len = m_len + 1;
         m_hi  = m_hi + int'(bus.clk_out);
      end
      if (bus.cfg_err) err_cnt = err_cnt + 1;
   end

   task automatic chk(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   task automatic push_exp(input int l);
      per_t p;
      p.len = l;
      p.hi  = l / 2;
      exp_q.push_back(p);
   endtask

   task automatic drain(input string nm);
      per_t e;
      per_t o;
      int   c;
      while (exp_q.size() > 0) begin
         c = 0;
         while (obs_q.size() == 0 && c < 1000) begin
            @(posedge clk);
            c++;
         end
         if (obs_q.size() == 0) begin
            chk({nm, "_timeout"}, obs_q.size(), 1);
            exp_q.delete();
            return;
         end
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         $display("period %s: len %0d hi %0d (want %0d/%0d)", nm, o.len, o.hi, e.len, e.hi);
         chk({nm, "_len"}, o.len, e.len);
         chk({nm, "_hi"}, o.hi, e.hi);
      end
      #1;
   endtask

   task automatic wait_tick(input string nm);
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!bus.tick && c < 600);
      chk({nm, "_tick_seen"}, int'(bus.tick), 1);
      #1;
   endtask

   task automatic go_idle();
      int c = 0;
      bus.en = 1'b0;
      while (bus.busy && c < 600) begin
         @(negedge clk);
         c++;
      end
      chk("go_idle_busy", int'(bus.busy), 0);
      #1;
      obs_q.delete();
   endtask

   task automatic set_idle_cfg(input int ci, input int cn, input int cd);
      @(posedge clk);
      #1;
      bus.cfg_valid = 1'b1;
      bus.cfg_int   = 8'(ci);
      bus.cfg_num   = 8'(cn);
      bus.cfg_den   = 8'(cd);
      @(posedge clk);
      #1;
      bus.cfg_valid = 1'b0;
      chk("idle_cfg_ready", int'(bus.cfg_ready), 1);
   endtask

   task automatic offer(input int ci, input int cn, input int cd);
      bus.cfg_valid = 1'b1;
      bus.cfg_int   = 8'(ci);
      bus.cfg_num   = 8'(cn);
      bus.cfg_den   = 8'(cd);
      @(posedge clk);
      #1;
      bus.cfg_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before 2ms");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{2,   0,   1,   '{2, 2, 2, 2, 2, 2}};
      vecs[1] = '{3,   1,   2,   '{3, 4, 3, 4, 3, 4}};
      vecs[2] = '{4,   2,   3,   '{4, 5, 5, 4, 5, 5}};
      vecs[3] = '{2,   1,   3,   '{2, 2, 3, 2, 2, 3}};
      vecs[4] = '{255, 1,   2,   '{255, 256, 255, 256, 255, 256}};
      vecs[5] = '{5,   254, 255, '{5, 6, 6, 6, 6, 6}};

      bus.en        = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_int   = 8'd2;
      bus.cfg_num   = 8'd0;
      bus.cfg_den   = 8'd1;

      #12;
      chk("rst_clk_out", int'(bus.clk_out), 0);
      chk("rst_tick", int'(bus.tick), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_ready", int'(bus.cfg_ready), 1);
      chk("rst_err", int'(bus.cfg_err), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Default divide-by-2 straight out of reset.
      @(posedge clk);
      #1;
      bus.en = 1'b1;
      @(posedge clk);
      #1;
      chk("start_tick", int'(bus.tick), 1);
      chk("start_clk_out", int'(bus.clk_out), 1);
      chk("start_busy", int'(bus.busy), 1);
      @(posedge clk);
      #1;
      chk("div2_tick_low", int'(bus.tick), 0);
      chk("div2_clk_low", int'(bus.clk_out), 0);
      for (int k = 0; k < 4; k++) push_exp(2);
      drain("div2");

      for (int v = 0; v < 6; v++) begin
         go_idle();
         set_idle_cfg(vecs[v].ci, vecs[v].cn, vecs[v].cd);
         obs_q.delete();
         bus.en = 1'b1;
         for (int k = 0; k < 6; k++) push_exp(vecs[v].lens[k]);
         drain($sformatf("vec%0d", v));
      end

      // Mid-period offer: current period finishes, next one uses the new ratio.
      go_idle();
      set_idle_cfg(3, 0, 1);
      bus.en = 1'b1;
      wait_tick("mid");
      obs_q.delete();
      @(posedge clk);
      #1;
      offer(5, 0, 1);
      chk("mid_ready_drop", int'(bus.cfg_ready), 0);
      push_exp(3); push_exp(5); push_exp(5);
      drain("mid");
      chk("mid_ready_rise", int'(bus.cfg_ready), 1);

      // Offer landing on the boundary edge: one more old period first.
      go_idle();
      set_idle_cfg(3, 0, 1);
      bus.en = 1'b1;
      wait_tick("bnd");
      obs_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      offer(5, 0, 1);
      chk("bnd_ready_drop", int'(bus.cfg_ready), 0);
      push_exp(3); push_exp(3); push_exp(5); push_exp(5);
      drain("bnd");
      chk("bnd_ready_rise", int'(bus.cfg_ready), 1);

`ifdef FRAC_DIV_CTRL_CHECK_EN
      // Illegal ratios while running: error pulse, ratio and ready untouched.
      go_idle();
      set_idle_cfg(3, 0, 1);
      bus.en = 1'b1;
      wait_tick("ill");
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         case (k)
            0:       offer(2, 0, 0);
            1:       offer(2, 5, 5);
            default: offer(1, 0, 1);
         endcase
         chk($sformatf("ill%0d_err", k), int'(bus.cfg_err), 1);
         chk($sformatf("ill%0d_ready", k), int'(bus.cfg_ready), 1);
         @(posedge clk);
         #1;
         chk($sformatf("ill%0d_err_width", k), int'(bus.cfg_err), 0);
      end
      wait_tick("ill_after");
      obs_q.delete();
      push_exp(3); push_exp(3); push_exp(3);
      drain("ill");
`endif

      // Stop mid-period: the period completes, then output parks low.
      go_idle();
      set_idle_cfg(4, 0, 1);
      bus.en = 1'b1;
      wait_tick("stop");
      obs_q.delete();
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      @(posedge clk);
      #1;
      chk("stop_busy_held", int'(bus.busy), 1);
      push_exp(4);
      drain("stop");
      chk("stop_busy", int'(bus.busy), 0);
      chk("stop_clk_out", int'(bus.clk_out), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("stop_no_tick", int'(bus.tick), 0);

      // en dropped and restored within one period: no gap.
      bus.en = 1'b1;
      wait_tick("resume");
      obs_q.delete();
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      @(posedge clk);
      #1;
      bus.en = 1'b1;
      push_exp(4); push_exp(4); push_exp(4);
      drain("resume");

      // Reset during the high phase: immediate low, back to divide-by-2.
      go_idle();
      set_idle_cfg(5, 0, 1);
      bus.en = 1'b1;
      wait_tick("rst");
      @(posedge clk);
      #1;
      chk("pre_rst_clk_out", int'(bus.clk_out), 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_clk_out", int'(bus.clk_out), 0);
      chk("async_rst_busy", int'(bus.busy), 0);
      chk("async_rst_tick", int'(bus.tick), 0);
      chk("async_rst_ready", int'(bus.cfg_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      obs_q.delete();
      push_exp(2); push_exp(2); push_exp(2);
      drain("post_rst");

`ifdef FRAC_DIV_CTRL_CHECK_EN
      chk("err_total", err_cnt, 3);
`else
      chk("err_total", err_cnt, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/frac_div_ctrl.md
# frac_div_ctrl

Run-time controller for the fractional clock divider path. It produces `clk_out` with average period `int + num/den` input cycles by alternating between short (`int`) and long (`int+1`) periods under a phase-accumulator schedule. It accepts new ratios through a valid/ready handshake, applies them only at period boundaries so no runt pulses occur, and starts and stops the output cleanly on `en`.

## Interface
- `CNT_W`, 8, width of integer part `cfg_int`.
- `FRAC_W`, 8, width of `cfg_num` and `cfg_den`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run request; level-sensitive.
- `cfg_valid`  in  1  new ratio offered.
- `cfg_ready`  out  1  controller can accept a ratio.
- `cfg_int`  in  CNT_W  integer divide part, legal range ≥ 2.
- `cfg_num`  in  FRAC_W  fractional numerator, legal when < `cfg_den`.
- `cfg_den`  in  FRAC_W  fractional denominator, legal when ≠ 0.
- `cfg_err`  out  1  one-cycle pulse when an offered ratio is rejected.
- `clk_out`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle pulse in the first cycle of each output period.
- `busy`  out  1  high in RUN and STOP.

## Operation
- Reset values:
  - Outputs: `clk_out` = 0, `tick` = 0, `cfg_err` = 0, `busy` = 0, `cfg_ready` = 1.
  - Internal state: state = IDLE, accumulator = 0, pending = 0.
  - Active ratio: `int` = 2, `num` = 0, `den` = 1, which gives divide-by-2.
- States:
  - **IDLE**: `clk_out` = 0. `en` = 1 goes to RUN and clears the accumulator.
  - **RUN**: generates periods. `en` = 0 goes to STOP.
  - **STOP**: completes the current period, then goes to IDLE. If `en` returns to 1 before the period ends, go back to RUN with no gap.
- Period length `L` is chosen in the first cycle of each period:
  - Compute `acc + num`, held in FRAC_W+1 bits.
  - If the sum ≥ `den`: `L` = `int+1` and `acc` ← sum − `den`.
  - Otherwise: `L` = `int` and `acc` ← sum.
  - Result: exactly `num` long periods in every `den` periods.
- Within a period, an internal counter runs 0..`L`−1 and is CNT_W+1 bits wide.
  - `clk_out` is 1 while the counter < `L>>1`, else 0.
  - Duty is 50% for even `L`; for odd `L` the low phase is longer by one cycle.
- Boundary = the cycle in which the counter equals `L`−1.
- Configuration handshake:
  - A transfer occurs when `cfg_valid` and `cfg_ready` are both high at a clock edge.
  - **In IDLE**, a legal ratio is written directly to the active ratio.
  - **In RUN or STOP**, a legal ratio is written to a shadow register, pending is set, and `cfg_ready` drops.
  - The shadow is copied to the active ratio on the next boundary edge where pending was already set before that edge. That edge also clears `acc` to 0, clears pending, and raises `cfg_ready`.
  - A transfer on the boundary edge itself therefore takes effect one full period later.
- An illegal ratio (`int` < 2, `den` = 0, or `num` ≥ `den`) causes:
  - a `cfg_err` pulse in the following cycle;
  - no change to the active ratio, the shadow, or `cfg_ready`.
- `rst` asserted at any time forces all reset values immediately, including mid-period. `clk_out` drops without completing its period.

## Timing
- `en` sampled high on edge k while in IDLE:
  - After edge k: `clk_out` = 1 and `tick` = 1 (first cycle of the first period).
  - `tick` recurs every `L` cycles.
- `en` sampled low in RUN: after the boundary edge, state = IDLE, `busy` = 0, `clk_out` = 0.
- Handshake timing:
  - `cfg_ready` falls the cycle after a shadow transfer.
  - `cfg_ready` rises the cycle after the boundary edge that applies the shadow.
- `cfg_err` has a latency of 1 cycle and a width of 1 cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `FRAC_DIV_CTRL_CHECK_EN`.
- **Defined**: the legality check is active and `cfg_err` behaves as described above.
- **Not defined**:
  - The check logic is removed, `cfg_err` is tied to 0, and every offered ratio is accepted.
  - Output for an illegal ratio is unspecified, but the block must not lock up: after a later legal ratio is applied, it must recover within one period.

## Structure
- Package `frac_div_pkg` holds:
  - the state enum (IDLE, RUN, STOP);
  - the default constants `DEF_INT` = 2, `DEF_NUM` = 0, `DEF_DEN` = 1;
  - `MIN_INT` = 2.
- Sub-module `frac_div_acc` is the phase accumulator.
  - Inputs: `clr`, `step`, `num`, `den`.
  - Output: a `long` flag.
  - It updates only on `step`, which the top level drives in the first cycle of each period.

## Test plan
- Reset, then `en` = 1 with the default ratio → `clk_out` toggles 1,0,1,0…; `tick` every 2 cycles; `busy` = 1.
- `int`=3, `num`=1, `den`=2 → period lengths 3,4,3,4…; high phases 1,2,1,2.
- `int`=4, `num`=2, `den`=3 → lengths 4,5,5 repeating; 14 cycles per 3 ticks.
- Running at divide-by-3, offer `int`=5 in the middle of a period:
  - `cfg_ready` drops next cycle;
  - the current period finishes at 3, one more period runs at 3 if the offer landed on the boundary, then lengths are 5;
  - `cfg_ready` rises again.
- Offer `den`=0, then `num`=5/`den`=5, then `int`=1 → three `cfg_err` pulses; output ratio unchanged; `cfg_ready` stays 1.
- Drop `en` mid-period → period completes, then `clk_out` = 0 and `busy` = 0. Assert `rst` mid-high phase → `clk_out` = 0 immediately and the ratio returns to divide-by-2.
